m2s_mem_responder: RTL and testbench

Memory-side responder for the Multi2Sim co-simulation bridge. It accepts byte-wide read/write requests issued by the PLI-driven access path (the `$m2s_access` initiator side), queues them in a small in-order request FIFO, and services them against an internal byte memory after a fixed, programmable access latency. It returns exactly one response per request over a valid/ready handshake, so the simulator side observes realistic memory timing from RTL.

---
 rtl/m2s_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_m2s_mem_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/m2s_mem_responder.sv
// Byte-wide memory responder for the Multi2Sim bridge: an in-order request FIFO feeding a
// fixed-latency access FSM. Optional `M2S_RESP_ADDR_CHECK_EN flags out-of-range addresses.
module m2s_mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  req_t        fifo_mem [FIFO_DEPTH];
  logic [7:0]  mem [MEM_DEPTH];

  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t      state_q, state_d;
  req_t        work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
`ifdef M2S_RESP_ADDR_CHECK_EN
  logic        rsp_err_q, rsp_err_d;
`endif

  logic          full, empty, push, pop;
  logic          mem_we, addr_ok;
  logic [IW-1:0] mem_idx;
  logic [ADDR_W:0] addr_ext;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign full      = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state_q == S_IDLE) && !empty;

  assign addr_ext = {1'b0, work_q.addr};
  assign mem_idx  = IW'(addr_ext % (ADDR_W+1)'(MEM_DEPTH));
`ifdef M2S_RESP_ADDR_CHECK_EN
  assign addr_ok  = (addr_ext < (ADDR_W+1)'(MEM_DEPTH));
`else
  assign addr_ok  = 1'b1;
`endif

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + {{PW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + {{PW{1'b0}}, 1'b1} : rd_ptr_q;
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef M2S_RESP_ADDR_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          work_d  = fifo_mem[rd_ptr_q[PW-1:0]];
          cnt_d   = 4'(LATENCY);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_write_d = work_q.write;
`ifdef M2S_RESP_ADDR_CHECK_EN
          rsp_err_d   = !addr_ok;
`endif
          if (!addr_ok) begin
            rsp_rdata_d = 8'h00;
          end else if (work_q.write) begin
            mem_we      = 1'b1;
            rsp_rdata_d = work_q.wdata;
          end else begin
            rsp_rdata_d = mem[mem_idx];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
`ifdef M2S_RESP_ADDR_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef M2S_RESP_ADDR_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Storage arrays carry no reset; memory contents survive rst by design.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= work_q.wdata;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef M2S_RESP_ADDR_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_m2s_mem_responder.sv
// Bench for m2s_mem_responder: directed + random requests, responses checked against an
// in-order queue and a byte-array memory model (honours `M2S_RESP_ADDR_CHECK_EN).
module tb_m2s_mem_responder;
  localparam int ADDR_W = 8, MEM_DEPTH = 128, LAT = 2, FD = 4;

  logic clk = 1'b0, rst;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;

  m2s_mem_responder #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit w; logic [7:0] a; logic [7:0] d; } req_s;

  int n_cmp = 0, n_fail = 0, cyc = 0, last_acc = 0;
  req_s pend[$];
  int rsp_cyc[$];
  logic [7:0] mm [MEM_DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: in-order byte memory, out-of-range handling per build option.
  function automatic void model(input req_s r, output logic ew, output logic [7:0] er, output logic ee);
    int idx;
    ew = r.w; ee = 1'b0; er = 8'h00;
`ifdef M2S_RESP_ADDR_CHECK_EN
    if (int'(r.a) >= MEM_DEPTH) begin ee = 1'b1; return; end
`endif
    idx = int'(r.a) % MEM_DEPTH;
    if (r.w) begin mm[idx] = r.d; er = r.d; end
    else er = mm[idx];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      req_s r;
      logic ew, ee;
      logic [7:0] er;
      rsp_cyc.push_back(cyc);
      chk("rsp_has_request", 32'(pend.size() != 0), 1);
      if (pend.size() != 0) begin
        r = pend.pop_front();
        model(r, ew, er, ee);
        chk("rsp_write", rsp_write, ew);
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_err", rsp_err, ee);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic push(input bit w, input logic [7:0] a, input logic [7:0] d, input bit unstick);
    int t = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && t < 500) begin
      @(posedge clk); #1;
      if (unstick) rsp_ready = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("push_accepted", req_ready, 1);
    @(posedge clk);
    pend.push_back('{w, a, d});
    #1;
    last_acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (pend.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    chk("drain_empty", pend.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] hold_d;
    logic hold_w;
    int n_before;
    rst = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_write", rsp_write, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Write then read location 0, with best-case latency check.
    rsp_cyc.delete();
    push(1'b1, 8'h00, 8'hAA, 1'b0);
    drain();
    chk("first_latency", rsp_cyc.size() > 0 ? rsp_cyc[0] - last_acc : -1, LAT + 2);
    push(1'b0, 8'h00, 8'h00, 1'b0);
    drain();

    for (int i = 0; i < MEM_DEPTH; i++) push(1'b1, 8'(i), 8'($urandom), 1'b0);
    drain();

    // Same-address ordering and back-to-back throughput.
    rsp_cyc.delete();
    push(1'b1, 8'h05, 8'h11, 1'b0);
    push(1'b1, 8'h05, 8'h22, 1'b0);
    push(1'b0, 8'h05, 8'h00, 1'b0);
    drain();
    chk("rsp_count3", rsp_cyc.size(), 3);
    if (rsp_cyc.size() == 3) begin
      chk("rsp_gap1", rsp_cyc[1] - rsp_cyc[0], LAT + 3);
      chk("rsp_gap2", rsp_cyc[2] - rsp_cyc[1], LAT + 3);
    end
    chk("model_mem5", mm[5], 8'h22);

    // Back-pressure: one in RESP + FD queued, then the next push stalls.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 8'(8'h40 + i), 8'($urandom), 1'b0);
    @(negedge clk);
    chk("full_ready_low", req_ready, 0);
    chk("held_rsp_valid", rsp_valid, 1);
    hold_d = rsp_rdata; hold_w = rsp_write;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h41; req_wdata = 8'h00;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready_low", req_ready, 0);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rdata_stable", rsp_rdata, hold_d);
      chk("stall_write_stable", rsp_write, hold_w);
      chk("stall_pending", pend.size(), 5);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    push(1'b0, 8'h41, 8'h00, 1'b0);
    drain();

    // Out-of-range: error or wrap depending on build.
    push(1'b0, 8'h85, 8'h00, 1'b0);
    push(1'b1, 8'h86, 8'h5C, 1'b0);
    push(1'b0, 8'h06, 8'h00, 1'b0);
    drain();

    repeat (150) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      push(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
    end
    rsp_ready = 1'b1;
    drain();

    // Reset while the head request is in WAIT with two more queued.
    push(1'b1, 8'h30, ~mm[8'h30], 1'b0);
    push(1'b1, 8'h31, ~mm[8'h31], 1'b0);
    push(1'b1, 8'h32, ~mm[8'h32], 1'b0);
    chk("pre_reset_no_rsp", rsp_valid, 0);
    rst = 1'b1;
    pend.delete();
    @(negedge clk);
    chk("mid_reset_rsp_valid", rsp_valid, 0);
    chk("mid_reset_req_ready", req_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    n_before = rsp_cyc.size();
    repeat (20) @(negedge clk);
    chk("no_rsp_after_reset", rsp_cyc.size(), n_before);
    @(posedge clk); #1;
    push(1'b0, 8'h30, 8'h00, 1'b0);
    push(1'b0, 8'h31, 8'h00, 1'b0);
    push(1'b0, 8'h32, 8'h00, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
